// File: rtl/fanout_fork_pkg.sv
// Shared sizing helpers for the fanout fork buffer and its per-load FIFOs.
package fanout_fork_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 2;

    // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // The occupancy count needs one extra bit so that "full" (== depth) is representable.
    function automatic int occ_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    typedef logic [occ_w(FIFO_DEPTH_DEFAULT)-1:0] occ_t;

endpackage

// File: rtl/fanout_load_fifo.sv
// Per-load FIFO: register-array storage, wrapping pointers, occupancy counter.
// The head word is read straight out of the register array, so a pushed word
// is visible on data_o in the cycle after the push.
module fanout_load_fifo
    import fanout_fork_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int OCC_W = occ_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Flush wins over any push or pop in the same cycle.
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    // Next pointer and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers and storage write; reset also clears storage so data_o reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_ok) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fanout_fork_buffer.sv
// One driver stream forked to NUM_LOADS independently draining load FIFOs,
// with per-load enable masking, flush and a count of accepted driver words.
module fanout_fork_buffer
    import fanout_fork_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_LOADS = 4,
    parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [NUM_LOADS-1:0]       load_en,
    input  logic                       flush,
    output logic [NUM_LOADS-1:0]       out_valid,
    input  logic [NUM_LOADS-1:0]       out_ready,
    output logic [NUM_LOADS*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]           accept_cnt
);

    logic [NUM_LOADS-1:0] full_w;
    logic [NUM_LOADS-1:0] empty_w;
    logic [NUM_LOADS-1:0] push_w;
    logic [NUM_LOADS-1:0] pop_w;
    logic                 accept;
    logic [CNT_W-1:0]     accept_cnt_q, accept_cnt_d;

    // Only enabled loads that are already full hold off the driver. Readiness
    // deliberately ignores out_ready so no combinational path runs consumer to producer.
    assign in_ready   = ~(|(load_en & full_w)) & ~flush;
    assign accept     = in_valid & in_ready;
    assign push_w     = {NUM_LOADS{accept}} & load_en;
    assign out_valid  = ~empty_w;
    assign pop_w      = out_valid & out_ready;
    assign accept_cnt = accept_cnt_q;

    for (genvar i = 0; i < NUM_LOADS; i++) begin : gen_load
        fanout_load_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_w[i]),
            .pop_i   (pop_w[i]),
            .flush_i (flush),
            .data_i  (in_data),
            .data_o  (out_data[i*WIDTH +: WIDTH]),
            .full_o  (full_w[i]),
            .empty_o (empty_w[i])
        );
    end

    // Every accepted word counts, including ones dropped because no load is enabled.
    always_comb begin
        accept_cnt_d = accept_cnt_q + CNT_W'(accept);
    end

    // Accept counter register; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) accept_cnt_q <= '0;
        else     accept_cnt_q <= accept_cnt_d;
    end

endmodule

// File: tb/tb_fanout_fork_buffer.sv
// Bench for fanout_fork_buffer: directed scenarios plus a random phase, all
// checked against a queue-per-load reference model.
module tb_fanout_fork_buffer;

    localparam int W  = 8;
    localparam int NL = 4;
    localparam int D  = 2;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [NL-1:0]     load_en;
    logic              flush;
    logic [NL-1:0]     out_valid;
    logic [NL-1:0]     out_ready;
    logic [NL*W-1:0]   out_data;
    logic [CW-1:0]     accept_cnt;

    int                checks = 0;
    int                errors = 0;
    logic [W-1:0]      mq [NL][$];
    logic [CW-1:0]     exp_cnt;
    bit                check_en;
    bit                last_acc;

    fanout_fork_buffer #(
        .WIDTH     (W),
        .NUM_LOADS (NL),
        .DEPTH     (D),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .load_en    (load_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mq[i].delete();
    endtask

    // One clock: compare outputs against the model before the edge, then advance the model.
    task automatic step();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = !flush;
        for (int i = 0; i < NL; i++)
            if (load_en[i] && mq[i].size() >= D) exp_rdy = 1'b0;
        if (check_en) begin
            chk("in_ready", in_ready, exp_rdy);
            chk("accept_cnt", accept_cnt, exp_cnt);
            for (int i = 0; i < NL; i++) begin
                chk($sformatf("out_valid[%0d]", i), out_valid[i], mq[i].size() != 0);
                if (mq[i].size() != 0)
                    chk($sformatf("out_data[%0d]", i), out_data[i*W +: W], mq[i][0]);
            end
        end
        last_acc = in_valid && exp_rdy && !rst;
        if (rst) begin
            model_clear();
            exp_cnt = '0;
        end else if (flush) begin
            model_clear();
        end else begin
            for (int i = 0; i < NL; i++)
                if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
            if (last_acc) begin
                for (int i = 0; i < NL; i++)
                    if (load_en[i]) mq[i].push_back(in_data);
                exp_cnt = exp_cnt + 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_en = 1'b1;
    endtask

    initial begin
        int k;
        int guard;
        logic [CW-1:0] cnt0;

        check_en  = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        load_en   = 4'hF;
        out_ready = 4'hF;
        exp_cnt   = '0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_accept_cnt", accept_cnt, 0);

        // broadcast 0x11..0x14 to all loads
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = W'(8'h11 + j);
            step();
        end
        in_valid = 1'b0;
        chk("bcast_cnt", accept_cnt, 4);
        chk("bcast_last_data3", out_data[3*W +: W], 8'h14);
        step();
        step();

        // load 2 stalls: holds two words, then blocks the driver
        out_ready = 4'b1011;
        k = 0;
        in_valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            in_data = W'(8'hA0 + k);
            step();
            if (last_acc) k++;
        end
        chk("stall_cnt", accept_cnt, 6);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_head2", out_data[2*W +: W], 8'hA0);
        // release: pop while full does not let the push through in the same cycle
        out_ready = 4'hF;
        for (int j = 0; j < 6; j++) begin
            in_data = W'(8'hA0 + k);
            step();
            if (last_acc) k++;
        end
        in_valid = 1'b0;
        step();
        step();

        // only loads 0 and 2 enabled; stalled load 1 must not affect in_ready
        load_en   = 4'b0101;
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        for (int j = 0; j < 6; j++) begin
            in_data = W'($urandom_range(0, 255));
            step();
        end
        chk("mask_in_ready", in_ready, 1);
        chk("mask_out_valid1", out_valid[1], 0);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        step();
        step();

        // no load enabled: words sink but are counted
        cnt0     = accept_cnt;
        load_en  = 4'h0;
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = W'(8'h30 + j);
            step();
        end
        in_valid = 1'b0;
        chk("sink_cnt", accept_cnt, cnt0 + 16'd3);
        chk("sink_out_valid", out_valid, 0);

        // fill, then flush one cycle
        load_en   = 4'hF;
        out_ready = 4'h0;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = W'(8'h50 + j);
            step();
        end
        flush = 1'b1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        step();

        // random traffic, with occasional flush and reset
        for (int j = 0; j < 400; j++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_data   = W'($urandom_range(0, 255));
            load_en   = NL'($urandom_range(0, 15));
            out_ready = NL'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst   = 1'b0;
        flush = 1'b0;

        // counter wrap
        load_en   = 4'h0;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        guard     = 0;
        while (exp_cnt != 16'hFFFF && guard < 70000) begin
            step();
            guard++;
        end
        chk("wrap_pre", accept_cnt, 16'hFFFF);
        step();
        in_valid = 1'b0;
        chk("wrap_post", accept_cnt, 16'h0000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
